bus_device_port: RTL and testbench
==================================

Name: bus_device_port

Overview:
- Device-side endpoint of the bus generator/arbiter protocol; one instance per device.
- Host writes packets into a TX FIFO. The block presents them to the bus as pndng/D_pop and retires one entry per bus pop.
- On the receive side, the bus delivers packets via push/D_push. Packets whose destination field matches this device's id or the broadcast code go into an RX FIFO that the host drains.
- Used by the testbench environment to model devices, and as synthesizable device glue.

Parameters:
- pckg_sz, 16, packet width in bits; destination id is bits [pckg_sz-1 : pckg_sz-8].
- depth, 8, entries per FIFO (TX and RX); power of two, minimum 2.
- id, 0, 8-bit destination id of this device.
- broadcast, 8'hFF, destination code accepted by every device.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- wr_en, input, 1, host writes wr_data into the TX FIFO.
- wr_data, input, pckg_sz, host packet to send.
- tx_full, output, 1, TX FIFO holds depth entries.
- tx_ovf, output, 1, one-cycle pulse: a write was dropped because the TX FIFO was full.
- pndng, output, 1, TX FIFO non-empty; goes to the bus.
- D_pop, output, pckg_sz, TX head entry (show-ahead); goes to the bus.
- pop, input, 1, bus consumes the TX head.
- push, input, 1, bus delivers D_push.
- D_push, input, pckg_sz, packet from the bus.
- rx_valid, output, 1, RX FIFO non-empty.
- rd_data, output, pckg_sz, RX head entry (show-ahead).
- rd_en, input, 1, host consumes the RX head.
- rx_drop, output, 1, one-cycle pulse: an RX packet was dropped (RX FIFO full).

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - Pointers and counts go to 0.
  - pndng=0, tx_full=0, tx_ovf=0, rx_valid=0, rx_drop=0.
  - D_pop and rd_data read 0; storage is cleared.
  - A reset asserted mid-transfer discards all entries in both FIFOs.
- TX FIFO:
  - Circular buffer with rd_ptr, wr_ptr and a count of width log2(depth)+1. Pointers wrap from depth-1 to 0.
  - A write on edge N makes pndng=1 and D_pop=data after edge N; first visibility is the cycle following the write.
  - pndng = (count!=0); tx_full = (count==depth). Both are decoded from registered count, with no combinational path from the inputs.
  - pop with pndng=1: head advances at the edge. pop with pndng=0 is ignored with no state change.
  - wr_en with tx_full=1: data is dropped and tx_ovf pulses the next cycle. This holds even if pop is asserted in the same cycle, so full is never bypassed.
  - wr_en and pop together on a non-full, non-empty FIFO: count is unchanged and both pointers advance.
  - wr_en and pop together on an empty FIFO: the write is accepted and the pop is ignored.
- RX filter and FIFO:
  - Accept condition: push=1 and (D_push[pckg_sz-1 -: 8]==id or ==broadcast).
  - Non-matching packets are silently ignored, with no rx_drop.
  - An accepted packet arriving while the RX FIFO is full is discarded, and rx_drop pulses the next cycle.
  - rd_en with rx_valid=1 advances the head; rd_en on empty is ignored.
  - Simultaneous accept and rd_en obey the same rules as TX: a full FIFO still drops.
- The stored packet is the full pckg_sz word, destination field included.

Optional Feature:
- Macro: BUS_PORT_STATS_EN.
- When defined, three additional outputs are present:
  - tx_sent_cnt [15:0]: successful pops.
  - rx_acc_cnt [15:0]: packets stored.
  - rx_drop_cnt [15:0]: rx_drop events.
- Counters are cleared by reset, saturate at 16'hFFFF, and update on the same edge as the event.
- When the macro is undefined, these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Reset mid-operation: 3 TX writes and 2 RX accepts, then reset held 1 cycle -> pndng=0, rx_valid=0, D_pop=0, rd_data=0 immediately, not waiting for clk.
- TX ordering: write 16'h0111, 16'h0222, 16'h0333; pop one per cycle -> D_pop sequence 0111, 0222, 0333; pndng falls after the third pop.
- TX full: depth=8, write 9 packets with no pop -> tx_full=1 after the 8th; the 9th is dropped with a one-cycle tx_ovf pulse; 8 pops return the first 8 in order.
- Concurrent write+pop at count=4 for 10 cycles -> count stays 4; data order is preserved across pointer wrap.
- RX filter, id=2: push 16'h02AA, 16'h03BB, 16'hFFCC -> RX holds 02AA then FFCC; 03BB is absent; no rx_drop.
- RX overflow: fill RX with 8 packets to id 2, push a 9th -> rx_drop pulses once; with BUS_PORT_STATS_EN, rx_acc_cnt=8 and rx_drop_cnt=1.

Source files
------------

// File: rtl/bus_device_port.sv
// Device-side bus endpoint: host TX FIFO presented as pndng/D_pop, RX FIFO fed by a destination filter.
// Define BUS_PORT_STATS_EN to add saturating tx_sent_cnt / rx_acc_cnt / rx_drop_cnt outputs.
module bus_device_port #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'h00,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [pckg_sz-1:0] wr_data,
  output logic               tx_full,
  output logic               tx_ovf,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rd_data,
  input  logic               rd_en,
  output logic               rx_drop
`ifdef BUS_PORT_STATS_EN
  ,
  output logic [15:0]        tx_sent_cnt,
  output logic [15:0]        rx_acc_cnt,
  output logic [15:0]        rx_drop_cnt
`endif
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  typedef logic [depth-1:0][pckg_sz-1:0] mem_t;

  mem_t          tx_mem_q, tx_mem_d;
  logic [AW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [AW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic          tx_ovf_q, tx_ovf_d;

  mem_t          rx_mem_q, rx_mem_d;
  logic [AW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [AW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic          rx_drop_q, rx_drop_d;

  logic tx_nempty, tx_full_w, tx_wr_ok, tx_rd_ok;
  logic rx_nempty, rx_full_w, rx_hit, rx_wr_ok, rx_rd_ok;
  logic [7:0] rx_dst;

  // Status decodes come only from the registered counts, so full is never bypassed by a same-cycle pop.
  assign tx_nempty = (tx_cnt_q != '0);
  assign tx_full_w = (tx_cnt_q == CW'(depth));
  assign tx_wr_ok  = wr_en && !tx_full_w;
  assign tx_rd_ok  = pop && tx_nempty;

  assign rx_nempty = (rx_cnt_q != '0);
  assign rx_full_w = (rx_cnt_q == CW'(depth));
  assign rx_dst    = D_push[pckg_sz-1 -: 8];
  assign rx_hit    = push && ((rx_dst == id) || (rx_dst == broadcast));
  assign rx_wr_ok  = rx_hit && !rx_full_w;
  assign rx_rd_ok  = rd_en && rx_nempty;

  always_comb begin
    tx_mem_d    = tx_mem_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_cnt_d    = tx_cnt_q;
    tx_ovf_d    = wr_en && tx_full_w;
    if (tx_wr_ok) begin
      tx_mem_d[tx_wr_ptr_q] = wr_data;
      tx_wr_ptr_d           = tx_wr_ptr_q + AW'(1);
    end
    if (tx_rd_ok) tx_rd_ptr_d = tx_rd_ptr_q + AW'(1);
    case ({tx_wr_ok, tx_rd_ok})
      2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  always_comb begin
    rx_mem_d    = rx_mem_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_cnt_d    = rx_cnt_q;
    rx_drop_d   = rx_hit && rx_full_w;
    if (rx_wr_ok) begin
      rx_mem_d[rx_wr_ptr_q] = D_push;
      rx_wr_ptr_d           = rx_wr_ptr_q + AW'(1);
    end
    if (rx_rd_ok) rx_rd_ptr_d = rx_rd_ptr_q + AW'(1);
    case ({rx_wr_ok, rx_rd_ok})
      2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_mem_q    <= '0;
      tx_rd_ptr_q <= '0;
      tx_wr_ptr_q <= '0;
      tx_cnt_q    <= '0;
      tx_ovf_q    <= 1'b0;
      rx_mem_q    <= '0;
      rx_rd_ptr_q <= '0;
      rx_wr_ptr_q <= '0;
      rx_cnt_q    <= '0;
      rx_drop_q   <= 1'b0;
    end else begin
      tx_mem_q    <= tx_mem_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_mem_q    <= rx_mem_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_drop_q   <= rx_drop_d;
    end
  end

  // Heads read zero while empty so stale entries never leak onto the bus or host.
  assign pndng    = tx_nempty;
  assign tx_full  = tx_full_w;
  assign tx_ovf   = tx_ovf_q;
  assign D_pop    = tx_nempty ? tx_mem_q[tx_rd_ptr_q] : '0;
  assign rx_valid = rx_nempty;
  assign rd_data  = rx_nempty ? rx_mem_q[rx_rd_ptr_q] : '0;
  assign rx_drop  = rx_drop_q;

`ifdef BUS_PORT_STATS_EN
  logic [15:0] tx_sent_q, tx_sent_d;
  logic [15:0] rx_acc_q, rx_acc_d;
  logic [15:0] rx_dcnt_q, rx_dcnt_d;

  always_comb begin
    tx_sent_d = tx_sent_q;
    rx_acc_d  = rx_acc_q;
    rx_dcnt_d = rx_dcnt_q;
    if (tx_rd_ok && (tx_sent_q != 16'hFFFF)) tx_sent_d = tx_sent_q + 16'd1;
    if (rx_wr_ok && (rx_acc_q != 16'hFFFF))  rx_acc_d  = rx_acc_q + 16'd1;
    if (rx_drop_d && (rx_dcnt_q != 16'hFFFF)) rx_dcnt_d = rx_dcnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_sent_q <= '0;
      rx_acc_q  <= '0;
      rx_dcnt_q <= '0;
    end else begin
      tx_sent_q <= tx_sent_d;
      rx_acc_q  <= rx_acc_d;
      rx_dcnt_q <= rx_dcnt_d;
    end
  end

  assign tx_sent_cnt = tx_sent_q;
  assign rx_acc_cnt  = rx_acc_q;
  assign rx_drop_cnt = rx_dcnt_q;
`endif

endmodule

// File: tb/tb_bus_device_port.sv
// Bench for bus_device_port (id=2, depth=8): vector table plus queue scoreboard for both FIFOs.
module tb_bus_device_port;

  localparam int DEPTH = 8;
  localparam logic [7:0] ID = 8'h02;

  logic        clk, reset;
  logic        wr_en, pop, push, rd_en;
  logic [15:0] wr_data, D_push;
  logic        tx_full, tx_ovf, pndng, rx_valid, rx_drop;
  logic [15:0] D_pop, rd_data;
`ifdef BUS_PORT_STATS_EN
  logic [15:0] tx_sent_cnt, rx_acc_cnt, rx_drop_cnt;
`endif

  bus_device_port #(.pckg_sz(16), .depth(DEPTH), .id(ID), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full), .tx_ovf(tx_ovf),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .rx_valid(rx_valid), .rd_data(rd_data), .rd_en(rd_en), .rx_drop(rx_drop)
`ifdef BUS_PORT_STATS_EN
    , .tx_sent_cnt(tx_sent_cnt), .rx_acc_cnt(rx_acc_cnt), .rx_drop_cnt(rx_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  int m_sent = 0, m_acc = 0, m_drop = 0;

  typedef struct {
    logic we; logic [15:0] wd; logic p;
    logic ps; logic [15:0] dp; logic re;
    logic e_pndng; logic e_rxv;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One bus cycle: update the scoreboard from the pre-edge model state, clock, then compare.
  task automatic cyc(input logic we, input logic [15:0] wd, input logic p,
                     input logic ps, input logic [15:0] dp, input logic re);
    logic tx_full_pre, rx_full_pre, hit, e_ovf, e_drop;
    logic [15:0] dummy;
    wr_en = we; wr_data = wd; pop = p; push = ps; D_push = dp; rd_en = re;
    tx_full_pre = (txq.size() == DEPTH);
    rx_full_pre = (rxq.size() == DEPTH);
    hit    = ps && ((dp[15:8] == ID) || (dp[15:8] == 8'hFF));
    e_ovf  = we && tx_full_pre;
    e_drop = hit && rx_full_pre;
    if (p && txq.size() != 0) begin dummy = txq.pop_front(); m_sent++; end
    if (we && !tx_full_pre) txq.push_back(wd);
    if (re && rxq.size() != 0) dummy = rxq.pop_front();
    if (hit && !rx_full_pre) begin rxq.push_back(dp); m_acc++; end
    if (e_drop) m_drop++;
    @(posedge clk); #1;
    wr_en = 1'b0; pop = 1'b0; push = 1'b0; rd_en = 1'b0;
    chk("pndng",    pndng,    txq.size() != 0);
    chk("tx_full",  tx_full,  txq.size() == DEPTH);
    chk("tx_ovf",   tx_ovf,   e_ovf);
    chk("D_pop",    D_pop,    (txq.size() != 0) ? txq[0] : 16'h0);
    chk("rx_valid", rx_valid, rxq.size() != 0);
    chk("rx_drop",  rx_drop,  e_drop);
    chk("rd_data",  rd_data,  (rxq.size() != 0) ? rxq[0] : 16'h0);
`ifdef BUS_PORT_STATS_EN
    chk("tx_sent_cnt", tx_sent_cnt, m_sent);
    chk("rx_acc_cnt",  rx_acc_cnt,  m_acc);
    chk("rx_drop_cnt", rx_drop_cnt, m_drop);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_pndng",    pndng,    1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_D_pop",    D_pop,    16'h0);
    chk("rst_rd_data",  rd_data,  16'h0);
    chk("rst_tx_full",  tx_full,  1'b0);
    chk("rst_tx_ovf",   tx_ovf,   1'b0);
    chk("rst_rx_drop",  rx_drop,  1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    txq.delete(); rxq.delete();
    m_sent = 0; m_acc = 0; m_drop = 0;
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0; pop = 1'b0; push = 1'b0; rd_en = 1'b0;
    wr_data = '0; D_push = '0;
    // TX ordering then RX filter: inputs and the expected pndng / rx_valid after the edge.
    tbl[0]  = '{1'b1, 16'h0111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 16'h0222, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 16'h0333, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h02AA, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h03BB, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFCC, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};

    #3;
    chk("init_pndng",    pndng,    1'b0);
    chk("init_rx_valid", rx_valid, 1'b0);
    chk("init_D_pop",    D_pop,    16'h0);
    chk("init_tx_full",  tx_full,  1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      if (i == 9) chk("rx_head_02AA", rd_data, 16'h02AA);
      if (i == 10) chk("rx_head_FFCC", rd_data, 16'hFFCC);
      cyc(tbl[i].we, tbl[i].wd, tbl[i].p, tbl[i].ps, tbl[i].dp, tbl[i].re);
      chk($sformatf("tbl%0d_pndng", i), pndng, tbl[i].e_pndng);
      chk($sformatf("tbl%0d_rxv", i), rx_valid, tbl[i].e_rxv);
    end

    // TX full: 9 writes without pop, the 9th is dropped.
    for (int i = 0; i < 9; i++) cyc(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
    chk("full_ovf_pulse", tx_ovf, 1'b1);
    // Write plus pop while full still drops the write.
    cyc(1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("full_bypass_ovf", tx_ovf, 1'b1);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    chk("ovf_one_cycle", tx_ovf, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("tx_drained", pndng, 1'b0);

    // Concurrent write+pop at count 4 across pointer wrap; also pop on empty with write.
    cyc(1'b1, 16'h5000, 1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 1; i < 4; i++) cyc(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 4; i < 14; i++) cyc(1'b1, 16'h5000 + 16'(i), 1'b1, 1'b0, 16'h0, 1'b0);
    chk("conc_head", D_pop, 16'h500A);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    chk("conc_empty", pndng, 1'b0);

    // Reset mid-operation discards both FIFOs immediately.
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'h7700 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'h0211, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'hFF22, 1'b0);
    do_reset();
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);

    // RX overflow: 8 accepted, 9th dropped, then drain.
    for (int i = 0; i < 8; i++) cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'h0200 + 16'(i), 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'h02EE, 1'b1);
    chk("rx_full_drop", rx_drop, 1'b1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 16'h0400, 1'b0);
    chk("rx_drop_once", rx_drop, 1'b0);
`ifdef BUS_PORT_STATS_EN
    chk("stat_rx_acc_8",  rx_acc_cnt,  16'd8);
    chk("stat_rx_drop_1", rx_drop_cnt, 16'd1);
`endif
    for (int i = 0; i < 8; i++) cyc(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("rx_drained", rx_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
